// File: rtl/tug_scorer_if.sv
// Tug-of-war scorer interface.
// Groups the player buttons, the controller handshake (clear, leds_on,
// led_control) and the scorer results (winrnd, leds, winner, scores).
//   master : drives buttons and controller signals, observes results
//   slave  : the scorer itself
interface tug_scorer_if #(
  parameter int NPOS = 7,
  parameter int SW   = 4
) ();
  logic            pbl;
  logic            pbr;
  logic            clear;
  logic            leds_on;
  logic [1:0]      led_control;
  logic            winrnd;
  logic [NPOS-1:0] leds;
  logic [1:0]      winner;
  logic [SW-1:0]   score_l;
  logic [SW-1:0]   score_r;

  modport master (
    output pbl, pbr, clear, leds_on, led_control,
    input  winrnd, leds, winner, score_l, score_r
  );

  modport slave (
    input  pbl, pbr, clear, leds_on, led_control,
    output winrnd, leds, winner, score_l, score_r
  );
endinterface

// File: rtl/tug_scorer.sv
// Tug-of-war rope-position datapath.
// Converts debounced button levels into push events, moves the rope
// position, detects a win (one-cycle winrnd pulse back to the controller),
// drives the LED bar and keeps saturating per-player win counts.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - tug_scorer_if.slave: pbl/pbr buttons, clear/leds_on/led_control
//          from the controller; winrnd, leds, winner, score_l, score_r out
module tug_scorer #(
  parameter int NPOS = 7,
  parameter int SW   = 4
) (
  input logic        clk,
  input logic        rst,
  tug_scorer_if.slave bus
);
  localparam int             PW   = $clog2(NPOS);
  localparam logic [PW-1:0]  CTR  = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0]  LAST = PW'(NPOS - 1);
  localparam logic [SW-1:0]  SMAX = '1;

  logic [PW-1:0]   pos;
  logic            pbl_q;
  logic            pbr_q;
  logic            clear_q;
  logic            lockout;
  logic            winrnd_q;
  logic [1:0]      winner_q;
  logic [SW-1:0]   score_l_q;
  logic [SW-1:0]   score_r_q;

  logic            push_l;
  logic            push_r;
  logic            round_start;
  logic            at_end;
  logic            frozen;
  logic            step_up;
  logic            step_dn;
  logic [NPOS-1:0] leds_c;

  assign push_l      = bus.pbl & ~pbl_q;
  assign push_r      = bus.pbr & ~pbr_q;
  assign round_start = clear_q & ~bus.clear;
  assign at_end      = (pos == '0) || (pos == LAST);

  // The win is registered one cycle after pos reaches an end, so lockout is
  // not yet set in that cycle; at_end blocks moves until it is.
  assign frozen = bus.clear | round_start | lockout | at_end;

  // In Dark a push is a false start and moves the rope the other way.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!frozen && (push_l ^ push_r)) begin
      if (bus.leds_on) begin
        step_dn = push_l;
        step_up = push_r;
      end else begin
        step_up = push_l;
        step_dn = push_r;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= CTR;
      pbl_q     <= 1'b0;
      pbr_q     <= 1'b0;
      clear_q   <= 1'b1;
      lockout   <= 1'b0;
      winrnd_q  <= 1'b0;
      winner_q  <= 2'b00;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      pbl_q    <= bus.pbl;
      pbr_q    <= bus.pbr;
      clear_q  <= bus.clear;
      winrnd_q <= 1'b0;
      if (round_start) begin
        pos      <= CTR;
        winner_q <= 2'b00;
        lockout  <= 1'b0;
      end else if (!bus.clear && !lockout && at_end) begin
        winrnd_q <= 1'b1;
        lockout  <= 1'b1;
        if (pos == '0) begin
          winner_q <= 2'b01;
          if (score_l_q != SMAX) score_l_q <= score_l_q + 1'b1;
        end else begin
          winner_q <= 2'b10;
          if (score_r_q != SMAX) score_r_q <= score_r_q + 1'b1;
        end
      end else if (step_up) begin
        pos <= pos + 1'b1;
      end else if (step_dn) begin
        pos <= pos - 1'b1;
      end
    end
  end

  always_comb begin
    leds_c = '0;
    if (bus.leds_on) begin
      if (bus.led_control == 2'b11) leds_c = '1;
      else if (bus.led_control[1])  leds_c[pos] = 1'b1;
    end
  end

  assign bus.leds    = leds_c;
  assign bus.winrnd  = winrnd_q;
  assign bus.winner  = winner_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
endmodule

// File: tb/tb_tug_scorer.sv
// Testbench for tug_scorer: a vector table of one-cycle input rows with
// expected LED/winner/winrnd values, hand-written reset and saturation
// sequences, and a win scoreboard checked whenever winrnd pulses.
module tb_tug_scorer;
  localparam int NPOS = 7;
  localparam int SW   = 2;
  localparam int CTR  = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  tug_scorer_if #(.NPOS(NPOS), .SW(SW)) bus ();

  tug_scorer #(.NPOS(NPOS), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            pbl;
    logic            pbr;
    logic            clear;
    logic            leds_on;
    logic [1:0]      lc;
    logic [NPOS-1:0] leds;
    logic            winrnd;
    logic [1:0]      winner;
    logic            sb;
    logic [1:0]      sb_winner;
    logic [SW-1:0]   sb_sl;
    logic [SW-1:0]   sb_sr;
  } vec_t;

  typedef struct {
    logic [1:0]    winner;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    int            due;
  } win_t;

  vec_t tbl[$];
  win_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic a, input logic b, input logic c, input logic d,
                              input logic [1:0] lc, input logic [NPOS-1:0] leds,
                              input logic w, input logic [1:0] wn);
    vec_t v;
    v.pbl = a; v.pbr = b; v.clear = c; v.leds_on = d; v.lc = lc;
    v.leds = leds; v.winrnd = w; v.winner = wn;
    v.sb = 1'b0; v.sb_winner = 2'b00; v.sb_sl = '0; v.sb_sr = '0;
    tbl.push_back(v);
  endfunction

  // Row whose push ends a round; the win is expected two cycles later.
  function automatic void add_win(input logic a, input logic b, input logic [NPOS-1:0] leds,
                                  input logic [1:0] wn, input logic [SW-1:0] sl,
                                  input logic [SW-1:0] sr);
    add(a, b, 1'b0, 1'b1, 2'b10, leds, 1'b0, 2'b00);
    tbl[tbl.size()-1].sb        = 1'b1;
    tbl[tbl.size()-1].sb_winner = wn;
    tbl[tbl.size()-1].sb_sl     = sl;
    tbl[tbl.size()-1].sb_sr     = sr;
  endfunction

  function automatic void expect_win(input logic [1:0] wn, input logic [SW-1:0] sl,
                                     input logic [SW-1:0] sr);
    win_t w;
    w.winner = wn; w.sl = sl; w.sr = sr; w.due = cyc + 2;
    sbq.push_back(w);
  endfunction

  // Scoreboard: every winrnd cycle must match a queued win, on time.
  always @(negedge clk) begin
    if (bus.winrnd === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("winrnd_unexpected", 32'(bus.winrnd), 32'd0);
      end else begin
        win_t e;
        e = sbq.pop_front();
        chk("win_cycle", 32'(cyc), 32'(e.due));
        chk("win_winner", 32'(bus.winner), 32'(e.winner));
        chk("win_score_l", 32'(bus.score_l), 32'(e.sl));
        chk("win_score_r", 32'(bus.score_r), 32'(e.sr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic right_round(input logic [SW-1:0] sr);
    logic [NPOS-1:0] e;
    bus.clear = 1'b1; bus.leds_on = 1'b1; bus.led_control = 2'b10;
    tick();
    bus.clear = 1'b0;
    tick();
    chk("rr_start_leds", 32'(bus.leds), 32'(7'b0001000));
    for (int j = 1; j <= 3; j++) begin
      bus.pbr = 1'b1;
      if (j == 3) expect_win(2'b10, '0, sr);
      tick();
      e = 7'b1 << (CTR + j);
      chk("rr_step_leds", 32'(bus.leds), 32'(e));
      bus.pbr = 1'b0;
      tick();
    end
    repeat (2) tick();
    chk("rr_score_r", 32'(bus.score_r), 32'(sr));
    chk("rr_score_l", 32'(bus.score_l), 32'd0);
    chk("rr_winner", 32'(bus.winner), 32'd2);
    chk("rr_end_leds", 32'(bus.leds), 32'(7'b1000000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // pbl pbr clear on lc    leds         winrnd winner
    add(0, 0, 1, 1, 2'b11, 7'b1111111, 0, 2'b00);   // lamp test
    add(0, 0, 1, 0, 2'b00, 7'b0000000, 0, 2'b00);   // dark
    add(0, 0, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);   // round start
    add(1, 0, 0, 1, 2'b10, 7'b0000100, 0, 2'b00);
    add(0, 0, 0, 1, 2'b10, 7'b0000100, 0, 2'b00);
    add(1, 0, 0, 1, 2'b10, 7'b0000010, 0, 2'b00);
    add(0, 0, 0, 1, 2'b10, 7'b0000010, 0, 2'b00);
    add_win(1, 0, 7'b0000001, 2'b01, 2'd1, 2'd0);   // left reaches end
    add(0, 0, 0, 1, 2'b10, 7'b0000001, 1, 2'b01);   // winrnd pulse
    add(0, 1, 0, 1, 2'b10, 7'b0000001, 0, 2'b01);   // locked out
    add(0, 0, 0, 1, 2'b10, 7'b0000001, 0, 2'b01);
    add(0, 0, 1, 1, 2'b10, 7'b0000001, 0, 2'b01);   // clear holds
    add(1, 0, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);   // round start, push ignored
    add(0, 0, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);
    add(1, 1, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);   // simultaneous cancel
    add(0, 0, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);
    add(0, 1, 0, 1, 2'b10, 7'b0010000, 0, 2'b00);   // pbr rises
    for (int i = 0; i < 19; i++)
      add(0, 1, 0, 1, 2'b10, 7'b0010000, 0, 2'b00); // held, no repeat
    add(0, 0, 0, 1, 2'b10, 7'b0010000, 0, 2'b00);
    add(0, 0, 1, 1, 2'b10, 7'b0010000, 0, 2'b00);
    add(0, 0, 0, 0, 2'b10, 7'b0000000, 0, 2'b00);   // round start in dark
    add(1, 0, 0, 0, 2'b10, 7'b0000000, 0, 2'b00);   // false start left
    add(0, 0, 0, 1, 2'b10, 7'b0010000, 0, 2'b00);   // shows pos 4
    add(0, 0, 1, 1, 2'b10, 7'b0010000, 0, 2'b00);   // frozen
    add(1, 0, 1, 1, 2'b10, 7'b0010000, 0, 2'b00);   // push ignored in clear
    add(0, 0, 1, 1, 2'b10, 7'b0010000, 0, 2'b00);
    add(0, 0, 0, 1, 2'b10, 7'b0001000, 0, 2'b00);   // back to centre
    add(0, 1, 0, 0, 2'b10, 7'b0000000, 0, 2'b00);   // false start right
    add(0, 0, 0, 1, 2'b10, 7'b0000100, 0, 2'b00);
    add(0, 0, 0, 1, 2'b01, 7'b0000000, 0, 2'b00);   // undefined code
    add(1, 1, 0, 0, 2'b10, 7'b0000000, 0, 2'b00);   // dark, both: no move
    add(0, 0, 0, 1, 2'b10, 7'b0000100, 0, 2'b00);
    add(0, 0, 0, 1, 2'b11, 7'b1111111, 0, 2'b00);
    add(0, 0, 0, 1, 2'b10, 7'b0000100, 0, 2'b00);

    rst = 1'b1;
    bus.pbl = 1'b0; bus.pbr = 1'b0; bus.clear = 1'b1;
    bus.leds_on = 1'b1; bus.led_control = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", 32'(bus.leds), 32'(7'b0001000));
    chk("rst_winrnd", 32'(bus.winrnd), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    chk("rst_score_l", 32'(bus.score_l), 32'd0);
    chk("rst_score_r", 32'(bus.score_r), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      bus.pbl = tbl[i].pbl;
      bus.pbr = tbl[i].pbr;
      bus.clear = tbl[i].clear;
      bus.leds_on = tbl[i].leds_on;
      bus.led_control = tbl[i].lc;
      if (tbl[i].sb) expect_win(tbl[i].sb_winner, tbl[i].sb_sl, tbl[i].sb_sr);
      tick();
      chk($sformatf("row%0d_leds", i), 32'(bus.leds), 32'(tbl[i].leds));
      chk($sformatf("row%0d_winrnd", i), 32'(bus.winrnd), 32'(tbl[i].winrnd));
      chk($sformatf("row%0d_winner", i), 32'(bus.winner), 32'(tbl[i].winner));
    end

    // Reset mid-play with the rope at position 1.
    bus.pbl = 1'b1;
    tick();
    chk("midrst_pre_leds", 32'(bus.leds), 32'(7'b0000010));
    bus.pbl = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_leds", 32'(bus.leds), 32'(7'b0001000));
    chk("midrst_score_l", 32'(bus.score_l), 32'd0);
    chk("midrst_winner", 32'(bus.winner), 32'd0);
    chk("midrst_winrnd", 32'(bus.winrnd), 32'd0);
    repeat (2) begin
      tick();
      chk("midrst_hold_winrnd", 32'(bus.winrnd), 32'd0);
    end
    bus.clear = 1'b1;
    rst = 1'b0;
    tick();

    // Right wins five rounds; the 2-bit counter saturates at 3.
    for (int r = 1; r <= 5; r++) right_round(SW'((r > 3) ? 3 : r));

    repeat (4) tick();
    chk("sb_pending_wins", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
